regfile_mp: RTL and testbench

Parametrised multi-port register file for the RISC-V core datapath, sitting between the ID stage (reads) and the WB stage (writes). It generalises the current regfile to a configurable number of read and write ports, with an x0-hardwired-zero rule and deterministic write-port priority. It also carries a per-register busy scoreboard: the issue stage marks a destination register pending, and writeback clears it. This lets the hazard unit stall on true RAW dependencies without decoding pipeline registers.

---
 rtl/regfile_mp_pkg.sv | 21 ++
 rtl/regfile_mp_scoreboard.sv | 54 +++++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared widths, limits and helpers for the multi-port register file.
// Optional write-through forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_RD     = 2;
  localparam int unsigned DEF_NUM_WR     = 2;

  localparam int unsigned MAX_RD = 4;
  localparam int unsigned MAX_WR = 2;

  // x0 is hardwired to zero
  localparam int unsigned REG_ZERO = 0;

  // LSB of field idx inside a packed bus of width-bit fields
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears, and a registered busy count.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_WR     = DEF_NUM_WR
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_issue_en,
  input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
  input  logic [NUM_WR-1:0]            i_wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_waddr,
  output logic [2**ADDR_WIDTH-1:0]     o_busy,
  output logic [ADDR_WIDTH:0]          o_busy_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0]    busy_nxt;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // Clears first, then the set so a younger issue wins over a same-cycle writeback
  always_comb begin
    busy_nxt = o_busy;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (i_wen[j] && (i_waddr[field_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH] != ZERO_ADDR)) begin
        busy_nxt[i_waddr[field_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (i_issue_en && (i_issue_addr != ZERO_ADDR)) begin
      busy_nxt[i_issue_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy     <= '0;
      o_busy_cnt <= '0;
    end else begin
      o_busy     <= busy_nxt;
      o_busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, highest-write-port priority and busy scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data (and clear busy) onto matching reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  parameter int unsigned NUM_WR     = DEF_NUM_WR
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
  output logic [NUM_RD-1:0]            o_rbusy,
  input  logic [NUM_WR-1:0]            i_wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] i_wdata,
  input  logic                         i_issue_en,
  input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
  output logic [ADDR_WIDTH:0]          o_busy_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] mem     [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [ADDR_WIDTH-1:0] raddr_a [NUM_RD];
  logic [ADDR_WIDTH-1:0] waddr_a [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_WR];
  logic [NUM_WR-1:0]     wr_valid;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign raddr_a[k] = i_raddr[field_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign waddr_a[j] = i_waddr[field_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wdata_a[j] = i_wdata[field_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
  end

  // A write survives only if no higher-indexed port targets the same register
  always_comb begin
    wr_valid = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_valid[j] = i_wen[j] && (waddr_a[j] != ZERO_ADDR);
      for (int unsigned h = j + 1; h < NUM_WR; h++) begin
        if (i_wen[h] && (waddr_a[h] == waddr_a[j])) begin
          wr_valid[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j]) begin
          mem[waddr_a[j]] <= wdata_a[j];
        end
      end
    end
  end

  regfile_mp_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_issue_en   (i_issue_en),
    .i_issue_addr (i_issue_addr),
    .i_wen        (i_wen),
    .i_waddr      (i_waddr),
    .o_busy       (busy),
    .o_busy_cnt   (o_busy_cnt)
  );

  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (raddr_a[k] != ZERO_ADDR) begin
        o_rdata[field_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = mem[raddr_a[k]];
        o_rbusy[k] = busy[raddr_a[k]];
`ifdef REGFILE_MP_BYPASS_EN
        // Forward in-flight writeback; a same-cycle issue to this register keeps it busy
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (i_rst_n && wr_valid[j] && (waddr_a[j] == raddr_a[k])) begin
            o_rdata[field_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = wdata_a[j];
            o_rbusy[k] = i_issue_en && (i_issue_addr == raddr_a[k]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a reference model predicts read data, busy and count.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [5:0]  busy_cnt;

  regfile_mp dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_raddr      (raddr),
    .o_rdata      (rdata),
    .o_rbusy      (rbusy),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .o_busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] ref_busy;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_cnt();
    logic [5:0] c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(ref_busy[i]);
    return c;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_busy = '0;
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : ref_mem[a];
  endfunction

  function automatic logic ref_rb(input logic [4:0] a);
    return (a == 5'd0) ? 1'b0 : ref_busy[a];
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                          input logic b0, input logic b1, input logic [5:0] cnt);
    exp_t e;
    e.tag = tag; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".rdata0"}, 64'(rdata[31:0]), 64'(e.d0));
    check({e.tag, ".rdata1"}, 64'(rdata[63:32]), 64'(e.d1));
    check({e.tag, ".rbusy0"}, 64'(rbusy[0]), 64'(e.b0));
    check({e.tag, ".rbusy1"}, 64'(rbusy[1]), 64'(e.b1));
    check({e.tag, ".busy_cnt"}, 64'(busy_cnt), 64'(e.cnt));
  endtask

  // Idle-write read of two registers, predicted from the model
  task automatic rd(input string tag, input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    wen = '0; issue_en = 1'b0;
    raddr = {a1, a0};
    push_exp(tag, ref_rd(a0), ref_rd(a1), ref_rb(a0), ref_rb(a1), ref_cnt());
    #1 pop_check();
  endtask

  // One clocked cycle of writes/issue; model applies clears then the set
  task automatic cyc(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic ie, input logic [4:0] ia);
    @(negedge clk);
    wen = {w1, w0}; waddr = {a1, a0}; wdata = {d1, d0};
    issue_en = ie; issue_addr = ia;
    @(posedge clk);
    if (w0 && a0 != 5'd0) begin ref_mem[a0] = d0; ref_busy[a0] = 1'b0; end
    if (w1 && a1 != 5'd0) begin ref_mem[a1] = d1; ref_busy[a1] = 1'b0; end
    if (ie && ia != 5'd0) ref_busy[ia] = 1'b1;
  endtask

  logic [31:0] byp_d;
  logic        byp_b;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0;
    ref_reset();
    repeat (2) @(posedge clk);
    rd("reset_state", 5'd5, 5'd6);
    @(negedge clk) rst_n = 1'b1;

    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
    rd("wr_x5", 5'd5, 5'd5);
    cyc(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0);
    rd("wr_x0", 5'd0, 5'd5);
    cyc(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0);
    rd("collide_x7", 5'd7, 5'd5);
    cyc(1, 5'd8, 32'hA8, 1, 5'd6, 32'hB6, 0, 5'd0);
    rd("dual_wr", 5'd8, 5'd6);

    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3);
    rd("issue_x3", 5'd3, 5'd0);
    cyc(0, 5'd0, 32'd0, 1, 5'd3, 32'h3333, 0, 5'd0);
    rd("clear_x3", 5'd3, 5'd7);
    cyc(1, 5'd3, 32'h4444, 0, 5'd0, 32'd0, 1, 5'd3);
    rd("set_clr_x3", 5'd3, 5'd3);
    cyc(1, 5'd3, 32'h5555, 0, 5'd0, 32'd0, 1, 5'd0);
    rd("issue_x0", 5'd3, 5'd0);

    // Same-cycle write and read of x9 while x9 is busy
    cyc(1, 5'd9, 32'h1111, 0, 5'd0, 32'd0, 1, 5'd9);
    @(negedge clk);
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'hCAFE};
    issue_en = 1'b0; raddr = {5'd9, 5'd9};
`ifdef REGFILE_MP_BYPASS_EN
    byp_d = 32'hCAFE; byp_b = 1'b0;
`else
    byp_d = 32'h1111; byp_b = 1'b1;
`endif
    push_exp("bypass_x9", byp_d, byp_d, byp_b, byp_b, ref_cnt());
    #1 pop_check();
    @(posedge clk);
    ref_mem[9] = 32'hCAFE; ref_busy[9] = 1'b0;
    rd("after_x9", 5'd9, 5'd9);

    for (int i = 1; i < 32; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'(i));
    rd("issue_all", 5'd1, 5'd31);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0);
    rd("issue_all_x0", 5'd0, 5'd17);

    for (int i = 1; i < 32; i += 2)
      cyc(1, 5'(i), 32'hA500_0000 | 32'(i), 1, 5'(i + 1), 32'h5A00_0000 | 32'(i + 1), 1, 5'd4);
    rd("filled", 5'd5, 5'd20);

    // Asynchronous reset in the middle of a cycle, no clock edge before the sample
    @(negedge clk);
    wen = '0; issue_en = 1'b0; raddr = {5'd20, 5'd5};
    #2 rst_n = 1'b0;
    ref_reset();
    push_exp("async_rst", 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
    #1 pop_check();
    rd("in_reset", 5'd4, 5'd31);
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 5'd5, 32'h600D, 0, 5'd0, 32'd0, 1, 5'd6);
    rd("post_rst", 5'd5, 5'd6);

    if (exp_q.size() != 0) check("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
